// File: rtl/cpu_clock_stretcher.sv
// 6502 PHI0 generator: splits clk_src into LOW/HIGH phases and stretches HIGH per chip select.
// Also provides halt/single-step and holds the CPU in reset for the first RESET_CYCLES clocks.
module cpu_clock_stretcher #(
  parameter int unsigned HALF_DIV     = 25,
  parameter logic [31:0] WAIT_CFG     = 32'h0000_0000,
  parameter int unsigned RESET_CYCLES = 8
) (
  input  logic       clk_src,
  input  logic       reset,
  input  logic [7:0] decoder,
  input  logic       run,
  input  logic       step,
  output logic       cpu_clk_in,
  output logic       cpu_rst_b,
  output logic       halted,
  output logic       wait_active
);

  typedef enum logic [1:0] {LOW, HIGH, HALT} state_t;

  localparam logic [11:0] LowLast = 12'(HALF_DIV - 1);
  localparam logic [11:0] HalfDiv = 12'(HALF_DIV);
  localparam logic [7:0]  RstInit = 8'(RESET_CYCLES);

  state_t      state_q, state_d;
  logic [11:0] phaseCnt_q, phaseCnt_d;
  logic [7:0]  rstCnt_q, rstCnt_d;
  logic [3:0]  waitCnt_q, waitCnt_d;
  logic        runMeta_q, runSync_q, stepMeta_q, stepSync_q;
  logic        clkOut_q, rstbOut_q, haltOut_q, waitOut_q;

  logic        holdActive;
  logic [3:0]  waitSel;
  logic [11:0] highLast;

  // Lowest-numbered active (low) select wins, so scan from the top down.
  function automatic logic [3:0] resolveWait(input logic [7:0] sel);
    logic [3:0] w;
    w = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!sel[i]) w = WAIT_CFG[4*i +: 4];
    end
    return w;
  endfunction

  assign holdActive = (rstCnt_q != 8'd0);
  assign waitSel    = resolveWait(decoder);
  assign highLast   = HalfDiv * (12'(waitCnt_q) + 12'd1) - 12'd1;

  always_ff @(posedge clk_src) begin
    if (reset) begin
      runMeta_q  <= 1'b0;
      runSync_q  <= 1'b0;
      stepMeta_q <= 1'b0;
      stepSync_q <= 1'b0;
    end else begin
      runMeta_q  <= run;
      runSync_q  <= runMeta_q;
      stepMeta_q <= step;
      stepSync_q <= stepMeta_q;
    end
  end

  always_ff @(posedge clk_src) begin
    if (reset) begin
      state_q    <= LOW;
      phaseCnt_q <= 12'd0;
      rstCnt_q   <= RstInit;
      waitCnt_q  <= 4'd0;
    end else begin
      state_q    <= state_d;
      phaseCnt_q <= phaseCnt_d;
      rstCnt_q   <= rstCnt_d;
      waitCnt_q  <= waitCnt_d;
    end
  end

  // Step is only consumed in HALT, so a pulse arriving in LOW or HIGH simply vanishes.
  always_comb begin
    state_d    = state_q;
    phaseCnt_d = phaseCnt_q + 12'd1;
    rstCnt_d   = rstCnt_q;
    waitCnt_d  = waitCnt_q;
    case (state_q)
      LOW: begin
        if (phaseCnt_q == LowLast) begin
          phaseCnt_d = 12'd0;
          if (runSync_q || holdActive) begin
            state_d   = HIGH;
            waitCnt_d = waitSel;
          end else begin
            state_d = HALT;
          end
        end
      end
      HIGH: begin
        if (phaseCnt_q == highLast) begin
          state_d    = LOW;
          phaseCnt_d = 12'd0;
          if (holdActive) rstCnt_d = rstCnt_q - 8'd1;
        end
      end
      HALT: begin
        phaseCnt_d = 12'd0;
        if (runSync_q || stepSync_q) begin
          state_d   = HIGH;
          waitCnt_d = waitSel;
        end
      end
      default: begin
        state_d    = LOW;
        phaseCnt_d = 12'd0;
      end
    endcase
  end

  // Outputs come from dedicated flops loaded with the next state so PHI0 is glitch-free.
  always_ff @(posedge clk_src) begin
    if (reset) begin
      clkOut_q  <= 1'b0;
      rstbOut_q <= 1'b0;
      haltOut_q <= 1'b0;
      waitOut_q <= 1'b0;
    end else begin
      clkOut_q  <= (state_d == HIGH);
      rstbOut_q <= (rstCnt_d == 8'd0);
      haltOut_q <= (state_d == HALT);
      waitOut_q <= (state_d == HIGH) && (waitCnt_d != 4'd0);
    end
  end

  assign cpu_clk_in  = clkOut_q;
  assign cpu_rst_b   = rstbOut_q;
  assign halted      = haltOut_q;
  assign wait_active = waitOut_q;

endmodule

// File: tb/tb_cpu_clock_stretcher.sv
// Scoreboard bench for cpu_clock_stretcher: expected HIGH phases are queued when stimulus is
// driven and compared when PHI0 falls; a second HALF_DIV=2 instance runs with a toggling run.
`timescale 1ns/1ps
module tb_cpu_clock_stretcher;

  // field0=3, field1=1, field2=5, field3=15
  localparam logic [31:0] WaitCfg = 32'h0000_F513;

  typedef struct {
    int len;
    int waitCycles;
  } exp_t;

  logic       clkSrc = 1'b0;
  logic       reset, run, step;
  logic [7:0] decoder;
  logic       cpuClk, cpuRstB, halted, waitActive;

  logic       reset2, run2, step2;
  logic [7:0] decoder2;
  logic       cpuClk2, cpuRstB2, halted2, waitActive2;

  int   checks = 0;
  int   failures = 0;
  exp_t expQ[$];

  always #10 clkSrc = ~clkSrc;

  cpu_clock_stretcher #(.HALF_DIV(25), .WAIT_CFG(WaitCfg), .RESET_CYCLES(8)) dut (
    .clk_src(clkSrc), .reset(reset), .decoder(decoder), .run(run), .step(step),
    .cpu_clk_in(cpuClk), .cpu_rst_b(cpuRstB), .halted(halted), .wait_active(waitActive)
  );

  cpu_clock_stretcher #(.HALF_DIV(2), .WAIT_CFG(32'h0), .RESET_CYCLES(4)) dut2 (
    .clk_src(clkSrc), .reset(reset2), .decoder(decoder2), .run(run2), .step(step2),
    .cpu_clk_in(cpuClk2), .cpu_rst_b(cpuRstB2), .halted(halted2), .wait_active(waitActive2)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic logic sampleSig(input int sel);
    case (sel)
      0:       return cpuClk;
      1:       return halted;
      default: return cpuRstB;
    endcase
  endfunction

  // Waits (at negedges) for a DUT output to reach a level; an expired budget is a failure.
  task automatic waitLevel(input int sel, input logic level, input int budget,
                           input string tag, output int cycles);
    cycles = 0;
    while (sampleSig(sel) !== level && cycles < budget) begin
      @(negedge clkSrc);
      cycles++;
    end
    if (sampleSig(sel) !== level) checkOutput({tag, "Timeout"}, 0, 1);
  endtask

  task automatic pushExp(input int len, input int w);
    exp_t item;
    item.len = len;
    item.waitCycles = w;
    expQ.push_back(item);
  endtask

  // Called just after PHI0 falls; the decoder value is stable across the whole LOW phase.
  task automatic applyStimulus(input logic [7:0] dec, input int len, input int w);
    int n;
    decoder = dec;
    pushExp(len, w);
    waitLevel(0, 1'b1, 40, "rise", n);
    waitLevel(0, 1'b0, 500, "fall", n);
  endtask

  // Monitor for the main instance: measures each HIGH phase and checks it against the queue.
  logic monEn = 1'b0;
  logic prevClk = 1'b0;
  int   highLen = 0;
  int   waitLen = 0;
  exp_t popped;

  always @(negedge clkSrc) begin
    if (monEn) begin
      if (cpuClk) begin
        highLen++;
        if (waitActive) waitLen++;
      end
      if (prevClk && !cpuClk) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedHigh", highLen, 0);
        end else begin
          popped = expQ.pop_front();
          checkOutput("highLen", highLen, popped.len);
          checkOutput("waitLen", waitLen, popped.waitCycles);
        end
        highLen = 0;
        waitLen = 0;
      end
      prevClk = cpuClk;
    end
  end

  // Monitor for the HALF_DIV=2 instance: phase extremes, halts during hold, reset-release time.
  logic live2 = 1'b0;
  logic prev2 = 1'b0;
  logic seenFall2 = 1'b0;
  int   hi2 = 0, lo2 = 0, minHi2 = 1000, maxHi2 = 0, minLo2 = 1000;
  int   haltInHold2 = 0, sawHalt2 = 0, waitSeen2 = 0, rstbAt2 = 0, cyc2 = 0;

  always @(posedge clkSrc) live2 <= !reset2;

  always @(negedge clkSrc) begin
    if (live2) begin
      cyc2++;
      if (cpuRstB2 && rstbAt2 == 0) rstbAt2 = cyc2;
      if (halted2 && !cpuRstB2) haltInHold2++;
      if (halted2) sawHalt2 = 1;
      if (waitActive2) waitSeen2++;
      if (cpuClk2 != prev2) begin
        if (prev2) begin
          if (hi2 < minHi2) minHi2 = hi2;
          if (hi2 > maxHi2) maxHi2 = hi2;
          seenFall2 = 1'b1;
        end else if (seenFall2) begin
          if (lo2 < minLo2) minLo2 = lo2;
        end
        hi2 = 0;
        lo2 = 0;
      end
      if (cpuClk2) hi2++;
      else lo2++;
      prev2 = cpuClk2;
    end
  end

  initial begin
    run2 = 1'b0;
    forever begin
      repeat (7) @(negedge clkSrc);
      run2 = ~run2;
    end
  end

  // Releases reset with run=1 and expects eight 25-cycle highs, PHI0 up at 25, cpu_rst_b at 400.
  task automatic releaseAndCheck(input string tag);
    int n, firstHigh;
    expQ.delete();
    highLen = 0;
    waitLen = 0;
    prevClk = 1'b0;
    for (int i = 0; i < 8; i++) pushExp(25, 0);
    monEn = 1'b1;
    decoder = 8'hFF;
    run = 1'b1;
    reset = 1'b0;
    n = 0;
    firstHigh = 0;
    while (!cpuRstB && n < 1000) begin
      @(negedge clkSrc);
      n++;
      if (cpuClk && firstHigh == 0) firstHigh = n;
    end
    checkOutput({tag, "FirstHigh"}, firstHigh, 25);
    checkOutput({tag, "RstbRise"}, n, 400);
  endtask

  initial begin
    logic [7:0] decTab [7];
    int lenTab [7];
    int waitTab [7];
    int n;
    decTab  = '{8'hFE, 8'hFF, 8'hFD, 8'hF9, 8'hFB, 8'h00, 8'hF7};
    lenTab  = '{100, 25, 50, 50, 150, 100, 400};
    waitTab = '{100, 0, 50, 50, 150, 100, 400};

    reset = 1'b1; reset2 = 1'b1;
    run = 1'b1; step = 1'b0; decoder = 8'hFF;
    step2 = 1'b0; decoder2 = 8'h00;
    repeat (4) @(negedge clkSrc);
    checkOutput("rstClk", cpuClk, 0);
    checkOutput("rstRstb", cpuRstB, 0);
    checkOutput("rstHalted", halted, 0);
    checkOutput("rstWait", waitActive, 0);

    reset2 = 1'b0;
    releaseAndCheck("boot");

    for (int i = 0; i < 7; i++) applyStimulus(decTab[i], lenTab[i], waitTab[i]);

    $display("[TB] halt and single-step");
    run = 1'b0;
    decoder = 8'hFF;
    waitLevel(1, 1'b1, 60, "haltEnter", n);
    checkOutput("haltLatency", n, 25);
    checkOutput("haltClkLow", cpuClk, 0);
    repeat (10) @(negedge clkSrc);
    checkOutput("haltHold", halted, 1);

    pushExp(25, 0);
    step = 1'b1;
    @(negedge clkSrc);
    step = 1'b0;
    waitLevel(0, 1'b1, 10, "stepRise", n);
    checkOutput("stepLatency", n, 2);
    checkOutput("stepHaltedDrop", halted, 0);
    waitLevel(0, 1'b0, 60, "stepFall", n);
    // A pulse six cycles into LOW must be dropped; HALT returns at the 25th LOW edge.
    repeat (5) @(negedge clkSrc);
    step = 1'b1;
    @(negedge clkSrc);
    step = 1'b0;
    waitLevel(1, 1'b1, 60, "reHalt", n);
    checkOutput("reHaltLow", n, 19);
    repeat (60) @(negedge clkSrc);
    checkOutput("stepInLowIgnored", halted, 1);
    checkOutput("sbDrainedHalt", expQ.size(), 0);

    pushExp(25, 0);
    run = 1'b1;
    step = 1'b1;
    @(negedge clkSrc);
    step = 1'b0;
    waitLevel(0, 1'b1, 10, "runStepRise", n);
    checkOutput("runStepLatency", n, 2);
    waitLevel(0, 1'b0, 60, "runStepFall", n);

    $display("[TB] reset in the middle of a stretched high");
    decoder = 8'hF7;
    monEn = 1'b0;
    waitLevel(0, 1'b1, 40, "w15Rise", n);
    repeat (50) @(negedge clkSrc);
    checkOutput("midWaitActive", waitActive, 1);
    reset = 1'b1;
    @(negedge clkSrc);
    checkOutput("midRstClk", cpuClk, 0);
    checkOutput("midRstRstb", cpuRstB, 0);
    checkOutput("midRstWait", waitActive, 0);
    repeat (3) @(negedge clkSrc);
    releaseAndCheck("again");

    run = 1'b0;
    waitLevel(1, 1'b1, 60, "halt2", n);
    checkOutput("haltLatency2", n, 25);
    monEn = 1'b0;
    reset = 1'b1;
    @(negedge clkSrc);
    checkOutput("haltRstHalted", halted, 0);
    checkOutput("haltRstClk", cpuClk, 0);
    checkOutput("sbEmpty", expQ.size(), 0);

    checkOutput("fastMinHigh", minHi2, 2);
    checkOutput("fastMaxHigh", maxHi2, 2);
    checkOutput("fastMinLow", minLo2, 2);
    checkOutput("fastHaltInHold", haltInHold2, 0);
    checkOutput("fastSawHalt", sawHalt2, 1);
    checkOutput("fastWaitSeen", waitSeen2, 0);
    checkOutput("fastRstbRise", rstbAt2, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
